// File: rtl/atmega_spi_s.sv
// ATmega-compatible SPI slave peripheral with SPCR/SPSR/SPDR on the core I/O bus.
// External SCK/SS/MOSI are brought into the clk domain through two-flop
// synchronisers; all protocol timing is derived from edges of the synced SCK.
// Optional feature: define ATMEGA_SPI_S_OVERRUN_EN to keep the first unread
// byte on overrun and report it in SPSR.OVR (bit 5).
module atmega_spi_s #(
    parameter int                           BUS_ADDR_DATA_LEN = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] SPCR_ADDR         = 8'h0D,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] SPSR_ADDR         = 8'h0E,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] SPDR_ADDR         = 8'h0F
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
    input  logic                         wr_i,
    input  logic                         rd_i,
    input  logic [7:0]                   bus_in_i,
    output logic [7:0]                   bus_out_o,
    output logic                         int_o,
    input  logic                         int_rst_i,
    output logic                         io_connect_o,
    input  logic                         sck_i,
    input  logic                         ss_i,
    input  logic                         mosi_i,
    output logic                         miso_o,
    output logic                         miso_oe_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  spcr_q;
    logic        spif_q;
    logic        wcol_q;
    logic        clr_arm_q;
    logic [7:0]  tx_buf_q;
    logic [7:0]  rx_buf_q;
    logic [7:0]  shifter_q;
    logic [2:0]  bit_cnt_q;
    logic        miso_q;
    logic [1:0]  sck_sync_q;
    logic [1:0]  ss_sync_q;
    logic [1:0]  mosi_sync_q;
    logic        sck_prev_q;
    logic        ss_prev_q;
`ifdef ATMEGA_SPI_S_OVERRUN_EN
    logic        ovr_q;
`endif

    logic        spie_s, spe_s, dord_s, cpol_s, cpha_s;
    logic        sck_s, ss_s, mosi_s;
    logic        sck_rise_s, sck_fall_s, ss_fall_s;
    logic        lead_s, trail_s, abort_s, active_s;
    logic        sample_s, shift_s, done_s;
    logic [7:0]  shift_in_s;
    logic        spcr_wr_s, spdr_wr_s, spsr_rd_s, spdr_rd_s;
    logic        wr_ok_s, clr_s, ovr_bit_s;
    logic [7:0]  spsr_s;

    assign spie_s = spcr_q[7];
    assign spe_s  = spcr_q[6];
    assign dord_s = spcr_q[5];
    assign cpol_s = spcr_q[3];
    assign cpha_s = spcr_q[2];

    assign sck_s  = sck_sync_q[1];
    assign ss_s   = ss_sync_q[1];
    assign mosi_s = mosi_sync_q[1];

    assign sck_rise_s = sck_s & ~sck_prev_q;
    assign sck_fall_s = ~sck_s & sck_prev_q;
    assign ss_fall_s  = ~ss_s & ss_prev_q;

    // Leading edge leaves the idle level set by CPOL; CPHA picks which edge samples.
    assign lead_s   = cpol_s ? sck_fall_s : sck_rise_s;
    assign trail_s  = cpol_s ? sck_rise_s : sck_fall_s;
    assign abort_s  = ~spe_s | ss_s;
    assign active_s = (state_q == ST_ACTIVE) & ~abort_s;
    assign sample_s = active_s & (cpha_s ? trail_s : lead_s);
    assign shift_s  = active_s & (cpha_s ? lead_s : trail_s);
    assign done_s   = sample_s & (bit_cnt_q == 3'd7);

    // Shifter image after taking in the current MOSI bit; also the completed byte.
    assign shift_in_s = dord_s ? {mosi_s, shifter_q[7:1]} : {shifter_q[6:0], mosi_s};

    assign spcr_wr_s = wr_i & (addr_i == SPCR_ADDR);
    assign spdr_wr_s = wr_i & (addr_i == SPDR_ADDR);
    assign spsr_rd_s = rd_i & (addr_i == SPSR_ADDR);
    assign spdr_rd_s = rd_i & (addr_i == SPDR_ADDR);

    // A data write is only safe before the first sample edge of a byte.
    assign wr_ok_s = (state_q != ST_ACTIVE) | (bit_cnt_q == 3'd0);
    assign clr_s   = spdr_rd_s & clr_arm_q;

`ifdef ATMEGA_SPI_S_OVERRUN_EN
    assign ovr_bit_s = ovr_q;
`else
    assign ovr_bit_s = 1'b0;
`endif
    assign spsr_s = {spif_q, wcol_q, ovr_bit_s, 5'b00000};

    assign int_o        = spie_s & spif_q;
    assign io_connect_o = spe_s;
    assign miso_oe_o    = spe_s & ~ss_s;
    assign miso_o       = miso_q;

    // Two-flop synchronisers for the pad inputs plus one history flop for edge detection.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= 2'b00;
            ss_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], sck_i};
            ss_sync_q   <= {ss_sync_q[0], ss_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            sck_prev_q  <= sck_sync_q[1];
            ss_prev_q   <= ss_sync_q[1];
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: deselect or disable always forces IDLE, aborting any partial byte.
    always_comb begin
        state_d = state_q;
        if (abort_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ss_fall_s) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD:   state_d = ST_ACTIVE;
                ST_ACTIVE: state_d = ST_ACTIVE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Serial datapath: load on select, shift on sample edges, drive MISO on shift edges.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            shifter_q <= 8'h00;
            bit_cnt_q <= 3'd0;
            miso_q    <= 1'b0;
        end else if (state_q == ST_LOAD) begin
            shifter_q <= tx_buf_q;
            bit_cnt_q <= 3'd0;
            if (!cpha_s) begin
                miso_q <= dord_s ? tx_buf_q[0] : tx_buf_q[7];
            end
        end else if (active_s) begin
            if (sample_s) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shifter_q <= done_s ? tx_buf_q : shift_in_s;
            end else if (shift_s) begin
                miso_q <= dord_s ? shifter_q[0] : shifter_q[7];
            end
        end else begin
            bit_cnt_q <= 3'd0;
        end
    end

    // Register file: control, transmit buffer, receive buffer and status flags.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            spcr_q    <= 8'h00;
            tx_buf_q  <= 8'h00;
            rx_buf_q  <= 8'h00;
            spif_q    <= 1'b0;
            wcol_q    <= 1'b0;
            clr_arm_q <= 1'b0;
`ifdef ATMEGA_SPI_S_OVERRUN_EN
            ovr_q     <= 1'b0;
`endif
        end else begin
            if (spcr_wr_s) begin
                spcr_q <= bus_in_i;
            end
            if (spdr_wr_s && wr_ok_s) begin
                tx_buf_q <= bus_in_i;
            end
`ifdef ATMEGA_SPI_S_OVERRUN_EN
            if (done_s && spif_q) begin
                ovr_q <= 1'b1;
            end else if (done_s) begin
                rx_buf_q <= shift_in_s;
            end else if (clr_s) begin
                ovr_q <= 1'b0;
            end
`else
            if (done_s) begin
                rx_buf_q <= shift_in_s;
            end
`endif
            // Completion beats any simultaneous clear.
            if (done_s) begin
                spif_q <= 1'b1;
            end else if (clr_s || int_rst_i) begin
                spif_q <= 1'b0;
            end
            if (spdr_wr_s && !wr_ok_s) begin
                wcol_q <= 1'b1;
            end else if (clr_s) begin
                wcol_q <= 1'b0;
            end
            if (spsr_rd_s && spif_q) begin
                clr_arm_q <= 1'b1;
            end else if (spdr_rd_s) begin
                clr_arm_q <= 1'b0;
            end
        end
    end

    // Read mux: zero unless a read strobe hits one of the three registers.
    always_comb begin
        bus_out_o = 8'h00;
        if (rd_i) begin
            if (addr_i == SPCR_ADDR) begin
                bus_out_o = spcr_q;
            end else if (addr_i == SPSR_ADDR) begin
                bus_out_o = spsr_s;
            end else if (addr_i == SPDR_ADDR) begin
                bus_out_o = rx_buf_q;
            end else begin
                bus_out_o = 8'h00;
            end
        end else begin
            bus_out_o = 8'h00;
        end
    end

endmodule

// File: tb/tb_atmega_spi_s.sv
// Directed testbench for atmega_spi_s: acts as the SPI master and the bus CPU.
// Honours ATMEGA_SPI_S_OVERRUN_EN for the overrun expectations.
module tb_atmega_spi_s;

    localparam logic [7:0] SPCR = 8'h0D;
    localparam logic [7:0] SPSR = 8'h0E;
    localparam logic [7:0] SPDR = 8'h0F;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic [7:0] bus_out;
    logic       int_w;
    logic       int_rst = 1'b0;
    logic       io_connect;
    logic       sck = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;

    int tests = 0;
    int fails = 0;
    logic [7:0] rdat;
    logic [7:0] mrx;

    atmega_spi_s dut (
        .clk_i(clk), .rst_n(rst_n), .addr_i(addr), .wr_i(wr), .rd_i(rd),
        .bus_in_i(bus_in), .bus_out_o(bus_out), .int_o(int_w), .int_rst_i(int_rst),
        .io_connect_o(io_connect), .sck_i(sck), .ss_i(ss), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        addr = a; bus_in = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        addr = a; rd = 1'b1;
        #1 d = bus_out;
        @(negedge clk);
        rd = 1'b0;
    endtask

    // Master transfer at clk/8. abort_after>0 raises SS before that bit index.
    // wcol_poke writes SPDR=8'h69 after the first sample edge (CPHA=0 only).
    // lat_chk checks int timing around the 8th sample edge (CPHA=0 only).
    task automatic xfer(input logic cpol, input logic cpha, input logic dord,
                        input logic [7:0] tx, input int abort_after,
                        input logic wcol_poke, input logic lat_chk,
                        output logic [7:0] rx);
        logic b;
        logic m;
        rx = 8'h00;
        sck = cpol; mosi = 1'b0;
        clk_n(4);
        ss = 1'b0;
        clk_n(8);
        chk("miso_oe_selected", {7'd0, miso_oe}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            if (abort_after != 0 && i == abort_after) begin
                ss = 1'b1;
                break;
            end
            b = dord ? tx[i] : tx[7-i];
            if (!cpha) begin
                mosi = b;
                clk_n(4);
                m = miso;
                sck = ~cpol;
                if (lat_chk && i == 7) begin
                    clk_n(2);
                    chk("int_before_latency", {7'd0, int_w}, 8'h00);
                    clk_n(1);
                    chk("int_at_latency", {7'd0, int_w}, 8'h01);
                    clk_n(1);
                end else if (wcol_poke && i == 0) begin
                    clk_n(3);
                    bus_write(SPDR, 8'h69);
                end else begin
                    clk_n(4);
                end
                sck = cpol;
            end else begin
                sck = ~cpol;
                mosi = b;
                clk_n(4);
                m = miso;
                sck = cpol;
                clk_n(4);
            end
            rx = dord ? {m, rx[7:1]} : {rx[6:0], m};
        end
        clk_n(8);
        ss = 1'b1;
        clk_n(8);
    endtask

    initial begin
        // Reset with inputs toggling
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            addr = (i % 2 == 0) ? SPCR : SPSR;
            wr = 1'b1; rd = 1'b1; bus_in = 8'hFF;
            sck = i[0]; ss = i[1]; mosi = i[2]; int_rst = i[0];
            @(negedge clk);
            chk("rst_bus_out", bus_out, 8'h00);
        end
        chk("rst_int", {7'd0, int_w}, 8'h00);
        chk("rst_miso_oe", {7'd0, miso_oe}, 8'h00);
        chk("rst_miso", {7'd0, miso}, 8'h00);
        chk("rst_io_connect", {7'd0, io_connect}, 8'h00);
        wr = 1'b0; rd = 1'b0; sck = 1'b0; ss = 1'b1; mosi = 1'b0; int_rst = 1'b0;
        clk_n(2);
        rst_n = 1'b1;
        clk_n(2);
        bus_read(SPCR, rdat); chk("rst_spcr", rdat, 8'h00);
        bus_read(SPSR, rdat); chk("rst_spsr", rdat, 8'h00);
        bus_read(SPDR, rdat); chk("rst_spdr", rdat, 8'h00);

        // Mode 0, MSB first: slave sends 3C, master sends AA
        bus_write(SPCR, 8'hC0);
        chk("io_connect_on", {7'd0, io_connect}, 8'h01);
        bus_read(SPCR, rdat); chk("spcr_readback", rdat, 8'hC0);
        bus_write(SPDR, 8'h3C);
        xfer(1'b0, 1'b0, 1'b0, 8'hAA, 0, 1'b0, 1'b1, mrx);
        chk("m0_miso_bits", mrx, 8'h3C);
        chk("miso_oe_deselected", {7'd0, miso_oe}, 8'h00);
        bus_read(SPSR, rdat); chk("m0_spsr", rdat, 8'h80);
        bus_read(SPDR, rdat); chk("m0_spdr", rdat, 8'hAA);
        bus_read(SPSR, rdat); chk("m0_spsr_cleared", rdat, 8'h00);
        chk("m0_int_cleared", {7'd0, int_w}, 8'h00);

        // Modes 1, 2, 3 with LSB first
        for (int md = 1; md < 4; md++) begin
            logic [7:0] cfg;
            cfg = 8'hE0;
            cfg[3] = md[1];
            cfg[2] = md[0];
            bus_write(SPCR, cfg);
            bus_write(SPDR, 8'hC5);
            xfer(md[1], md[0], 1'b1, 8'h55, 0, 1'b0, 1'b0, mrx);
            chk("lsb_miso_bits", mrx, 8'hC5);
            bus_read(SPSR, rdat); chk("lsb_spsr", rdat, 8'h80);
            bus_read(SPDR, rdat); chk("lsb_spdr", rdat, 8'h55);
        end

        // Write collision mid-byte
        bus_write(SPCR, 8'hC0);
        bus_write(SPDR, 8'h96);
        xfer(1'b0, 1'b0, 1'b0, 8'hF0, 0, 1'b1, 1'b0, mrx);
        chk("wcol_miso_bits", mrx, 8'h96);
        bus_read(SPSR, rdat); chk("wcol_spsr", rdat, 8'hC0);
        bus_read(SPDR, rdat); chk("wcol_spdr", rdat, 8'hF0);
        bus_read(SPSR, rdat); chk("wcol_spsr_cleared", rdat, 8'h00);
        xfer(1'b0, 1'b0, 1'b0, 8'hA5, 0, 1'b0, 1'b0, mrx);
        chk("wcol_tx_unchanged", mrx, 8'h96);
        bus_read(SPSR, rdat); chk("wcol2_spsr", rdat, 8'h80);
        bus_read(SPDR, rdat); chk("wcol2_spdr", rdat, 8'hA5);

        // Abort after 4 bits, then a full byte
        xfer(1'b0, 1'b0, 1'b0, 8'hFF, 4, 1'b0, 1'b0, mrx);
        chk("abort_int", {7'd0, int_w}, 8'h00);
        bus_read(SPSR, rdat); chk("abort_spsr", rdat, 8'h00);
        xfer(1'b0, 1'b0, 1'b0, 8'h0F, 0, 1'b0, 1'b0, mrx);
        bus_read(SPSR, rdat); chk("after_abort_spsr", rdat, 8'h80);
        bus_read(SPDR, rdat); chk("after_abort_spdr", rdat, 8'h0F);
        bus_read(SPSR, rdat); chk("after_abort_cleared", rdat, 8'h00);

        // Two bytes without clearing SPIF
        xfer(1'b0, 1'b0, 1'b0, 8'h11, 0, 1'b0, 1'b0, mrx);
        xfer(1'b0, 1'b0, 1'b0, 8'h22, 0, 1'b0, 1'b0, mrx);
        chk("ovr_int_set", {7'd0, int_w}, 8'h01);
        @(negedge clk);
        int_rst = 1'b1;
        @(negedge clk);
        int_rst = 1'b0;
        chk("int_rst_clears", {7'd0, int_w}, 8'h00);
        bus_read(SPSR, rdat);
`ifdef ATMEGA_SPI_S_OVERRUN_EN
        chk("ovr_spsr", rdat, 8'h20);
        bus_read(SPDR, rdat); chk("ovr_spdr_first_kept", rdat, 8'h11);
`else
        chk("ovr_spsr", rdat, 8'h00);
        bus_read(SPDR, rdat); chk("ovr_spdr_newest", rdat, 8'h22);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
